// File: rtl/ifetch_unit_pkg.sv
// Shared encodings and constants for the instruction-fetch unit and its next-PC helper.
package ifetch_unit_pkg;

    localparam int          ROM_AW_DEF = 9;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSEL_INC  = 2'b00,
        PCSEL_BR   = 2'b01,
        PCSEL_J    = 2'b10,
        PCSEL_HOLD = 2'b11
    } pc_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_e;

endpackage

// File: rtl/ifetch_unit_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or pseudo-direct jump.
module ifetch_next_pc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] br_offset,
    input  logic [25:0] jmp_target,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] br_disp;

    assign pc_plus4 = pc + 32'd4;
    assign br_disp  = {{14{br_offset[15]}}, br_offset, 2'b00};

    always_comb begin
        next_pc = pc;
        case (pc_sel_e'(pc_sel))
            PCSEL_INC:  next_pc = pc_plus4;
            PCSEL_BR:   next_pc = pc_plus4 + br_disp;
            PCSEL_J:    next_pc = {pc_plus4[31:28], jmp_target, 2'b00};
            PCSEL_HOLD: next_pc = pc;
            default:    next_pc = pc;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the PC, strobes the instruction ROM and captures
// the returned word into the instruction register.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int          ROM_AW   = ROM_AW_DEF,
    parameter int          WAIT_CYC = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [1:0]        pc_sel,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       jmp_target,
    output logic              rom_nce,
    output logic              rom_re,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_d,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic              busy,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              addr_err
);

    localparam int               CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              nce_q, nce_d;
    logic              re_q, re_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       next_pc;
    logic              pc_legal;

    ifetch_next_pc u_next_pc (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .br_offset  (br_offset),
        .jmp_target (jmp_target),
        .next_pc    (next_pc),
        .pc_plus4   (pc_plus4)
    );

    assign pc_legal = (pc_q[1:0] == 2'b00) && ((pc_q >> (ROM_AW + 2)) == 32'd0);

    // An illegal fetch never raises the strobes, so re_q doubles as the "capture ROM data" flag.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        nce_d      = nce_q;
        re_d       = re_q;
        addr_d     = addr_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_d = next_pc;
                end
                if (fetch_req) begin
                    state_d = ST_READ;
                    addr_d  = pc_q[ROM_AW+1:2];
                    cnt_d   = '0;
                    if (pc_legal) begin
                        nce_d = 1'b0;
                        re_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_LAST) begin
                    ir_d       = re_q ? rom_d : NOP;
                    ir_valid_d = 1'b1;
                    nce_d      = 1'b1;
                    re_d       = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            nce_q      <= 1'b1;
            re_q       <= 1'b0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            nce_q      <= nce_d;
            re_q       <= re_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_nce  = nce_q;
    assign rom_re   = re_q;
    assign rom_addr = addr_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign busy     = (state_q == ST_READ);
    assign pc       = pc_q;
    assign addr_err = err_q;

endmodule
